// File: rtl/g2_run_ctrl_if.sv
// Valid/ready handshake bundle between the sources, the g2 core and the host.
// The run controller only gates these lines; no data passes through it.
interface g2_run_ctrl_if;
    logic a1_src_v;
    logic a1_src_r;
    logic a1_v;
    logic a1_r;
    logic a2_src_v;
    logic a2_src_r;
    logic a2_v;
    logic a2_r;
    logic g2_v;
    logic g2_r;
    logic host_v;
    logic host_r;
    logic host_last;

    // Controller side
    modport slave (
        input  a1_src_v, a1_r, a2_src_v, a2_r, g2_v, host_r,
        output a1_src_r, a1_v, a2_src_r, a2_v, g2_r, host_v, host_last
    );

    // Sources / core / host side
    modport master (
        output a1_src_v, a1_r, a2_src_v, a2_r, g2_v, host_r,
        input  a1_src_r, a1_v, a2_src_r, a2_v, g2_r, host_v, host_last
    );
endinterface

// File: rtl/g2_run_ctrl.sv
// Run sequencer for the g2 histogram core: clear, acquire a fixed number of a1 events,
// drain the pipeline, then stream the histogram to the host with a last-word marker.
module g2_run_ctrl #(
    parameter int unsigned CntBit   = 32,
    parameter int unsigned ClrCyc   = 2048,
    parameter int unsigned DrainCyc = 16,
    parameter int unsigned G2Words  = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [CntBit-1:0] cfg_events_i,
    g2_run_ctrl_if.slave      bus,
    output logic              core_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o
);

    localparam int unsigned MaxCyc = (ClrCyc > DrainCyc) ? ClrCyc : DrainCyc;
    localparam int unsigned TmrW   = $clog2(MaxCyc + 1);
    localparam int unsigned RdW    = $clog2(G2Words);

    localparam logic [TmrW-1:0] ClrLast   = TmrW'(ClrCyc - 1);
    localparam logic [TmrW-1:0] DrainLast = TmrW'(DrainCyc - 1);
    localparam logic [RdW-1:0]  RdLast    = RdW'(G2Words - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAcq,
        StDrain,
        StRead,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [CntBit-1:0] ev_cnt_q, ev_cnt_d;
    logic [CntBit-1:0] ev_target_q, ev_target_d;
    logic [RdW-1:0]    rd_cnt_q, rd_cnt_d;
    logic              core_rst_q, core_rst_d;
    logic              aborted_q, aborted_d;

    logic gate;
    logic rd_en;
    logic a1_hs;
    logic host_hs;

    // Both event streams share one gate so they open and close on the same cycle
    assign gate    = (state_q == StAcq) && (ev_cnt_q != ev_target_q);
    assign rd_en   = (state_q == StRead);
    assign a1_hs   = bus.a1_src_v & bus.a1_r & gate;
    assign host_hs = bus.g2_v & bus.host_r & rd_en;

    assign bus.a1_src_r  = bus.a1_r & gate;
    assign bus.a1_v      = bus.a1_src_v & gate;
    assign bus.a2_src_r  = bus.a2_r & gate;
    assign bus.a2_v      = bus.a2_src_v & gate;
    assign bus.g2_r      = bus.host_r & rd_en;
    assign bus.host_v    = bus.g2_v & rd_en;
    assign bus.host_last = bus.g2_v & rd_en & (rd_cnt_q == RdLast);

    assign core_rst_o = core_rst_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StDone);
    assign aborted_o  = aborted_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        ev_cnt_d    = ev_cnt_q;
        ev_target_d = ev_target_q;
        rd_cnt_d    = rd_cnt_q;
        core_rst_d  = 1'b0;
        aborted_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    ev_target_d = cfg_events_i;
                    ev_cnt_d    = '0;
                    timer_d     = '0;
                    rd_cnt_d    = '0;
                    core_rst_d  = 1'b1;
                    state_d     = StClear;
                end
            end
            StClear: begin
                if (timer_q == ClrLast) begin
                    timer_d = '0;
                    state_d = StAcq;
                end else begin
                    timer_d    = timer_q + 1'b1;
                    core_rst_d = 1'b1;
                end
            end
            StAcq: begin
                if (a1_hs) ev_cnt_d = ev_cnt_q + 1'b1;
                // Leaves after the final handshake, or at once for a zero target
                if (ev_cnt_d == ev_target_q) state_d = StDrain;
            end
            StDrain: begin
                if (timer_q == DrainLast) begin
                    timer_d = '0;
                    state_d = StRead;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StRead: begin
                if (host_hs) begin
                    if (rd_cnt_q == RdLast) begin
                        rd_cnt_d = '0;
                        state_d  = StDone;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (abort_i && (state_q != StIdle)) begin
            state_d     = StIdle;
            timer_d     = '0;
            ev_cnt_d    = '0;
            ev_target_d = '0;
            rd_cnt_d    = '0;
            core_rst_d  = 1'b0;
            aborted_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            ev_cnt_q    <= '0;
            ev_target_q <= '0;
            rd_cnt_q    <= '0;
            core_rst_q  <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ev_cnt_q    <= ev_cnt_d;
            ev_target_q <= ev_target_d;
            rd_cnt_q    <= rd_cnt_d;
            core_rst_q  <= core_rst_d;
            aborted_q   <= aborted_d;
        end
    end

endmodule

// File: tb/tb_g2_run_ctrl.sv
// Self-checking bench for g2_run_ctrl: table of runs, random runs against a counting
// model, and hand sequences for abort and asynchronous reset.
module tb_g2_run_ctrl;

    localparam int unsigned CntBit   = 16;
    localparam int unsigned ClrCyc   = 12;
    localparam int unsigned DrainCyc = 5;
    localparam int unsigned G2Words  = 10;
    localparam int          Budget   = 5000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic              abort_i;
    logic [CntBit-1:0] cfg_events_i;
    logic              core_rst_o;
    logic              busy_o;
    logic              done_o;
    logic              aborted_o;

    g2_run_ctrl_if bus ();

    g2_run_ctrl #(
        .CntBit  (CntBit),
        .ClrCyc  (ClrCyc),
        .DrainCyc(DrainCyc),
        .G2Words (G2Words)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .cfg_events_i(cfg_events_i),
        .bus         (bus),
        .core_rst_o  (core_rst_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .aborted_o   (aborted_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Observation counters for the current run
    int mon_target;
    int n_crst, n_crst_rise, n_a1, n_a2, n_host, n_last, n_done, n_abt, n_inv;
    bit crst_prev;
    int d_src, d_core, d_host;

    // Core stand-in: word index it presents, advanced on each g2 handshake
    int core_idx;
    always @(posedge clk or posedge rst) begin
        if (rst) core_idx <= 0;
        else if (core_rst_o) core_idx <= 0;
        else if (bus.g2_v && bus.g2_r) core_idx <= core_idx + 1;
    end

    typedef struct {
        int cfg;
        int d_src;
        int d_core;
        int d_host;
        bit poke;
        int exp_a1;
        int exp_lat;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Cycles from first CLEAR cycle to the DONE cycle with everything always ready
    function automatic int exp_lat(input int cfg);
        return ClrCyc + ((cfg > 0) ? cfg : 1) + DrainCyc + G2Words + 1;
    endfunction

    function automatic bit roll(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    task automatic drive_rand();
        bus.a1_src_v = roll(d_src);
        bus.a2_src_v = roll(d_src);
        bus.a1_r     = roll(d_core);
        bus.a2_r     = roll(d_core);
        bus.g2_v     = roll(d_core);
        bus.host_r   = roll(d_host);
    endtask

    task automatic mon_clear(input int target);
        mon_target  = target;
        n_crst      = 0;
        n_crst_rise = 0;
        n_a1        = 0;
        n_a2        = 0;
        n_host      = 0;
        n_last      = 0;
        n_done      = 0;
        n_abt       = 0;
        n_inv       = 0;
        crst_prev   = 1'b0;
    endtask

    task automatic mon_sample();
        if (core_rst_o) begin
            n_crst++;
            if (!crst_prev) n_crst_rise++;
        end
        crst_prev = core_rst_o;
        if (core_rst_o && (bus.a1_v || bus.a1_src_r || bus.a2_v || bus.a2_src_r ||
                           bus.host_v || bus.g2_r)) n_inv++;
        if (bus.a1_v && !bus.a1_src_v) n_inv++;
        if (bus.a2_v && !bus.a2_src_v) n_inv++;
        if (bus.a1_r && (bus.a1_v != (bus.a1_src_v && bus.a1_src_r))) n_inv++;
        if (bus.a2_r && (bus.a2_v != (bus.a2_src_v && bus.a2_src_r))) n_inv++;
        if (bus.a1_r && bus.a2_r && (bus.a1_src_r != bus.a2_src_r)) n_inv++;
        if (n_a1 >= mon_target && (bus.a1_v || bus.a1_src_r || bus.a2_v || bus.a2_src_r))
            n_inv++;
        if (bus.a1_src_v && bus.a1_src_r) n_a1++;
        if (bus.a2_src_v && bus.a2_src_r) n_a2++;
        if (bus.host_v && !bus.g2_v) n_inv++;
        if (bus.g2_r && !bus.host_r) n_inv++;
        if (bus.host_last && !bus.host_v) n_inv++;
        if (bus.host_r && (bus.host_v != (bus.g2_v && bus.g2_r))) n_inv++;
        if (bus.host_v && (bus.host_last != (n_host == int'(G2Words) - 1))) n_inv++;
        if (bus.host_v && bus.host_r) begin
            if (core_idx != n_host) n_inv++;
            if (bus.host_last) n_last++;
            n_host++;
        end
        if (done_o) n_done++;
        if (aborted_o) n_abt++;
    endtask

    task automatic run_one(input string name, input int cfg, input int ds, input int dc,
                           input int dh, input bit poke, input int e_a1, input int e_lat);
        int lat;
        d_src  = ds;
        d_core = dc;
        d_host = dh;
        lat    = -1;
        mon_clear(cfg);
        @(posedge clk) #1;
        start_i      = 1'b1;
        cfg_events_i = CntBit'(cfg);
        drive_rand();
        for (int c = 1; c <= Budget; c++) begin
            @(posedge clk) #1;
            start_i = poke ? roll(50) : 1'b0;
            if (poke) cfg_events_i = CntBit'($urandom);
            drive_rand();
            @(negedge clk);
            mon_sample();
            if (done_o) begin
                lat = c;
                break;
            end
        end
        @(posedge clk) #1;
        start_i = 1'b0;
        drive_rand();
        @(negedge clk);
        mon_sample();
        chk({name, ".done"}, n_done, 1);
        chk({name, ".idle_after"}, int'(busy_o), 0);
        chk({name, ".core_rst_cycles"}, n_crst, ClrCyc);
        chk({name, ".core_rst_pulses"}, n_crst_rise, 1);
        chk({name, ".a1_handshakes"}, n_a1, e_a1);
        chk({name, ".host_words"}, n_host, G2Words);
        chk({name, ".host_last"}, n_last, 1);
        chk({name, ".invariants"}, n_inv, 0);
        chk({name, ".aborted"}, n_abt, 0);
        if (e_a1 == 0) chk({name, ".a2_handshakes"}, n_a2, 0);
        if (e_lat > 0) chk({name, ".latency"}, lat, e_lat);
    endtask

    initial begin
        bit seen;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        cfg_events_i = '0;
        bus.a1_src_v = 1'b1;
        bus.a2_src_v = 1'b1;
        bus.a1_r     = 1'b1;
        bus.a2_r     = 1'b1;
        bus.g2_v     = 1'b1;
        bus.host_r   = 1'b1;
        d_src = 100; d_core = 100; d_host = 100;
        mon_clear(0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.outputs", int'({core_rst_o, busy_o, done_o, aborted_o, bus.a1_v,
            bus.a1_src_r, bus.a2_v, bus.a2_src_r, bus.g2_r, bus.host_v, bus.host_last}), 0);
        rst = 1'b0;

        // start and abort together in idle: nothing happens
        @(posedge clk) #1;
        start_i = 1'b1;
        abort_i = 1'b1;
        @(posedge clk) #1;
        start_i = 1'b0;
        abort_i = 1'b0;
        @(negedge clk);
        chk("idle.start_abort", int'({busy_o, aborted_o, core_rst_o}), 0);

        tbl[0] = '{5, 100, 100, 100, 1'b0, 5, exp_lat(5)};
        tbl[1] = '{0, 100, 100, 100, 1'b0, 0, exp_lat(0)};
        tbl[2] = '{1, 100, 100, 100, 1'b0, 1, exp_lat(1)};
        tbl[3] = '{3, 60, 70, 50, 1'b0, 3, 0};
        tbl[4] = '{6, 100, 100, 45, 1'b0, 6, 0};
        tbl[5] = '{4, 80, 80, 60, 1'b1, 4, 0};
        tbl[6] = '{2, 100, 100, 100, 1'b1, 2, exp_lat(2)};
        for (int i = 0; i < 7; i++) begin
            run_one($sformatf("tbl%0d", i), tbl[i].cfg, tbl[i].d_src, tbl[i].d_core,
                    tbl[i].d_host, tbl[i].poke, tbl[i].exp_a1, tbl[i].exp_lat);
        end

        // Abort on the third acquisition handshake
        d_src = 100; d_core = 100; d_host = 100;
        mon_clear(10);
        @(posedge clk) #1;
        start_i      = 1'b1;
        cfg_events_i = CntBit'(10);
        drive_rand();
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk) #1;
            start_i = 1'b0;
            @(negedge clk);
            mon_sample();
            if (busy_o && !core_rst_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk("abort.acq_reached", int'(seen), 1);
        @(posedge clk) #1;
        @(negedge clk);
        mon_sample();
        @(posedge clk) #1;
        abort_i = 1'b1;
        @(negedge clk);
        mon_sample();
        chk("abort.hs3_open", int'(bus.a1_v), 1);
        @(posedge clk) #1;
        abort_i = 1'b0;
        @(negedge clk);
        mon_sample();
        chk("abort.gates_closed", int'({bus.a1_v, bus.a1_src_r, bus.a2_v, bus.a2_src_r,
            bus.g2_r, core_rst_o, busy_o}), 0);
        chk("abort.pulse", int'(aborted_o), 1);
        chk("abort.a1_count", n_a1, 3);
        @(posedge clk) #1;
        @(negedge clk);
        chk("abort.pulse_single", int'(aborted_o), 0);
        run_one("abort.rerun", 5, 100, 100, 100, 1'b0, 5, exp_lat(5));

        for (int i = 0; i < 6; i++) begin
            int cfg;
            cfg = int'($urandom_range(0, 15));
            run_one($sformatf("rand%0d", i), cfg, int'($urandom_range(40, 100)),
                    int'($urandom_range(40, 100)), int'($urandom_range(30, 100)),
                    1'b0, cfg, 0);
        end

        // Asynchronous reset in the middle of readout
        d_src = 100; d_core = 100; d_host = 100;
        mon_clear(2);
        @(posedge clk) #1;
        start_i      = 1'b1;
        cfg_events_i = CntBit'(2);
        drive_rand();
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk) #1;
            start_i = 1'b0;
            @(negedge clk);
            if (bus.host_v) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst.read_reached", int'(seen), 1);
        @(posedge clk) #2;
        rst = 1'b1;
        #1;
        chk("rst.async_outputs", int'({core_rst_o, busy_o, done_o, aborted_o, bus.a1_v,
            bus.a1_src_r, bus.a2_v, bus.a2_src_r, bus.g2_r, bus.host_v, bus.host_last}), 0);
        @(negedge clk);
        rst = 1'b0;
        run_one("rst.rerun", 5, 100, 100, 100, 1'b0, 5, exp_lat(5));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
